// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch controller
package fetch_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR_WORD = 32'h0000_0013;
  typedef enum logic [2:0] {BOOT, ISSUE, WAIT, HOLD, HALT} fetch_state_e;
endpackage

// File: rtl/fetch_controller.sv
// fetch_controller: sequences the PC and imem port, hands instructions to decode
module fetch_controller import fetch_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_INSTR_WORD)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic            pc_stall,
  output logic            pc_branch_taken,
  output logic [XLEN-1:0] pc_branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  output logic            fetch_fault
);
  fetch_state_e state, state_next;
  logic kill, kill_next;
  logic [XLEN-1:0] hold;
  logic fault, redir, granted, bypass, held;
  assign fault = redirect && (redirect_target[1:0] != 2'b00) && state != HALT;
  assign redir = redirect && (redirect_target[1:0] == 2'b00) && state != HALT;
  assign granted = state == ISSUE && imem_gnt && !fault;
  assign bypass = state == WAIT && imem_rvalid && !kill && !redirect;
  assign held = state == HOLD && !redirect;
  assign pc_stall = !(redir || granted);
  assign pc_branch_taken = redir;
  assign pc_branch_target = redirect_target;
  assign imem_req = state == ISSUE;
  assign imem_addr = pc;
  assign instr_valid = bypass || held;
  assign instr = held ? hold : bypass ? imem_rdata : NOP_INSTR;
  // Next-state and kill-flag logic; a fault overrides all sequencing
  always_comb begin
    state_next = state;
    kill_next = kill;
    if (fault) begin
      state_next = HALT;
      kill_next = 1'b0;
    end else begin
      case (state)
        BOOT: state_next = ISSUE;
        ISSUE: if (imem_gnt) begin
          state_next = WAIT;
          kill_next = redir;
        end
        WAIT: if (imem_rvalid) begin
          kill_next = 1'b0;
          state_next = (kill || redir || instr_ready) ? ISSUE : HOLD;
        end else if (redir) kill_next = 1'b1;
        HOLD: state_next = (redir || instr_ready) ? ISSUE : HOLD;
        HALT: state_next = HALT;
        default: state_next = BOOT;
      endcase
    end
  end
  // State, kill flag, sticky fault, instruction address and hold register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
      kill <= 1'b0;
      fetch_fault <= 1'b0;
      instr_pc <= '0;
      hold <= '0;
    end else begin
      state <= state_next;
      kill <= kill_next;
      if (fault) fetch_fault <= 1'b1;
      if (granted) instr_pc <= pc;
      if (bypass && !instr_ready) hold <= imem_rdata;
    end
  end
endmodule
